ikaopll_pg_sched: RTL

- Slot sequencer and parameter feeder for the IKAOPLL phase generator.
- Holds the per-channel FNUM/BLOCK/KEYON registers and the per-operator MUL/PM registers, written through a CPU-side request/ack port.
- Walks the 18-operator time-division frame and presents each slot's FNUM/BLOCK/MUL/PM to the phase generator.
- Drives the frame strobes (CYCLE_17/20/21), RHYTHM_EN, and phase-reset requests generated from key-on rising edges.

---
 rtl/ikaopll_pg_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ikaopll_pg_sched.sv
// Slot sequencer and parameter feeder for the IKAOPLL phase generator.
// Holds channel/operator parameter registers, walks the 18-slot frame, and issues key-on phase resets.
module ikaopll_pg_sched (
    input  logic       emuclk,
    input  logic       i_RST_n,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_WR_REQ,
    input  logic [1:0] i_WR_SEL,
    input  logic [4:0] i_WR_IDX,
    input  logic [7:0] i_WR_DATA,
    output logic       o_WR_ACK,
    output logic [8:0] o_FNUM,
    output logic [2:0] o_BLOCK,
    output logic [3:0] o_MUL,
    output logic       o_PM,
    output logic       o_PG_PHASE_RST,
    output logic       o_RHYTHM_EN,
    output logic       o_CYCLE_17,
    output logic       o_CYCLE_20,
    output logic       o_CYCLE_21,
    output logic [4:0] o_SLOT
);

    localparam int NUM_CH = 9;
    localparam int NUM_OP = 18;
    localparam logic [4:0] LAST_SLOT = 5'd17;

    typedef enum logic [1:0] {
        SEL_FNUM_LO = 2'd0,
        SEL_KON_BLK = 2'd1,
        SEL_OP      = 2'd2,
        SEL_RHYTHM  = 2'd3
    } wr_sel_e;

    // Slot -> operator index; channel is op >> 1, carrier when op is odd.
    function automatic logic [4:0] slot_to_op(input logic [4:0] slot);
        case (slot)
            5'd0:    slot_to_op = 5'd0;
            5'd1:    slot_to_op = 5'd2;
            5'd2:    slot_to_op = 5'd4;
            5'd3:    slot_to_op = 5'd1;
            5'd4:    slot_to_op = 5'd3;
            5'd5:    slot_to_op = 5'd5;
            5'd6:    slot_to_op = 5'd6;
            5'd7:    slot_to_op = 5'd8;
            5'd8:    slot_to_op = 5'd10;
            5'd9:    slot_to_op = 5'd7;
            5'd10:   slot_to_op = 5'd9;
            5'd11:   slot_to_op = 5'd11;
            5'd12:   slot_to_op = 5'd12;
            5'd13:   slot_to_op = 5'd14;
            5'd14:   slot_to_op = 5'd16;
            5'd15:   slot_to_op = 5'd13;
            5'd16:   slot_to_op = 5'd15;
            5'd17:   slot_to_op = 5'd17;
            default: slot_to_op = 5'd0;
        endcase
    endfunction

    logic [4:0]        cnt;
    logic              stg_full;
    wr_sel_e           stg_sel;
    logic [4:0]        stg_idx;
    logic [7:0]        stg_data;

    logic [8:0]        fnum_q  [NUM_CH];
    logic [2:0]        block_q [NUM_CH];
    logic [NUM_CH-1:0] keyon_q;
    logic [3:0]        mul_q   [NUM_OP];
    logic [NUM_OP-1:0] pm_q;
    logic [NUM_OP-1:0] pend_q;
    logic              rhythm_q;

    logic [8:0]        fnum_d  [NUM_CH];
    logic [2:0]        block_d [NUM_CH];
    logic [NUM_CH-1:0] keyon_d;
    logic [3:0]        mul_d   [NUM_OP];
    logic [NUM_OP-1:0] pm_d;
    logic [NUM_OP-1:0] pend_d;
    logic [NUM_OP-1:0] set_mask;
    logic [NUM_OP-1:0] clr_mask;
    logic              rhythm_d;

    logic              step;
    logic              commit;
    logic [4:0]        cnt_next;
    logic [4:0]        op_sel;
    logic [3:0]        ch_sel;
    logic [3:0]        wr_ch;
    logic              ch_ok;
    logic              op_ok;
    logic              phase_rst;

    // The staged write is folded into the *_d copies first so the output mux
    // sees a write to the slot being presented on the same step.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        step      = ~i_phi1_NCEN_n;
        commit    = step & stg_full;
        cnt_next  = (cnt == LAST_SLOT) ? 5'd0 : cnt + 5'd1;
        op_sel    = slot_to_op(cnt_next);
        ch_sel    = op_sel[4:1];
        wr_ch     = stg_idx[3:0];
        ch_ok     = (stg_idx < 5'd9);
        op_ok     = (stg_idx < 5'd18);

        fnum_d    = fnum_q;
        block_d   = block_q;
        keyon_d   = keyon_q;
        mul_d     = mul_q;
        pm_d      = pm_q;
        rhythm_d  = rhythm_q;
        set_mask  = '0;
        clr_mask  = '0;

        if (commit) begin
            case (stg_sel)
                SEL_FNUM_LO: if (ch_ok) fnum_d[wr_ch][7:0] = stg_data;
                SEL_KON_BLK: if (ch_ok) begin
                    fnum_d[wr_ch][8] = stg_data[0];
                    block_d[wr_ch]   = stg_data[3:1];
                    keyon_d[wr_ch]   = stg_data[4];
                    if (!keyon_q[wr_ch] && stg_data[4]) begin
                        set_mask[{wr_ch, 1'b0}] = 1'b1;
                        set_mask[{wr_ch, 1'b1}] = 1'b1;
                    end
                end
                SEL_OP: if (op_ok) begin
                    mul_d[stg_idx] = stg_data[3:0];
                    pm_d[stg_idx]  = stg_data[4];
                end
                default: rhythm_d = stg_data[0];
            endcase
        end

        // A key-on landing on the presented operator wins over its clear.
        clr_mask[op_sel] = step;
        pend_d    = (pend_q & ~clr_mask) | set_mask;
        phase_rst = pend_q[op_sel] | set_mask[op_sel];
    end

    always_ff @(posedge emuclk) begin
        if (!i_RST_n) begin
            // NOTE: the parameter register file is reset along with the control state,
            // since software expects every channel to start silent at FNUM/MUL 0.
            fnum_q         <= '{default: '0};
            block_q        <= '{default: '0};
            mul_q          <= '{default: '0};
            keyon_q        <= '0;
            pm_q           <= '0;
            pend_q         <= '0;
            rhythm_q       <= 1'b0;
            cnt            <= LAST_SLOT;
            stg_full       <= 1'b0;
            stg_sel        <= SEL_FNUM_LO;
            stg_idx        <= '0;
            stg_data       <= '0;
            o_WR_ACK       <= 1'b0;
            o_FNUM         <= '0;
            o_BLOCK        <= '0;
            o_MUL          <= '0;
            o_PM           <= 1'b0;
            o_PG_PHASE_RST <= 1'b0;
            o_CYCLE_17     <= 1'b0;
            o_CYCLE_20     <= 1'b0;
            o_CYCLE_21     <= 1'b0;
            o_SLOT         <= '0;
        end else begin
            o_WR_ACK <= commit;
            if (commit) begin
                stg_full <= 1'b0;
            end else if (!stg_full && i_WR_REQ) begin
                stg_full <= 1'b1;
                stg_sel  <= wr_sel_e'(i_WR_SEL);
                stg_idx  <= i_WR_IDX;
                stg_data <= i_WR_DATA;
            end

            if (step) begin
                cnt            <= cnt_next;
                o_SLOT         <= cnt_next;
                fnum_q         <= fnum_d;
                block_q        <= block_d;
                keyon_q        <= keyon_d;
                mul_q          <= mul_d;
                pm_q           <= pm_d;
                pend_q         <= pend_d;
                rhythm_q       <= rhythm_d;
                o_FNUM         <= fnum_d[ch_sel];
                o_BLOCK        <= block_d[ch_sel];
                o_MUL          <= mul_d[op_sel];
                o_PM           <= pm_d[op_sel];
                o_PG_PHASE_RST <= phase_rst;
                o_CYCLE_17     <= (cnt_next == 5'd17);
                o_CYCLE_20     <= (cnt_next == 5'd2);
                o_CYCLE_21     <= (cnt_next == 5'd3);
            end
        end
    end

    assign o_RHYTHM_EN = rhythm_q;

endmodule
